// File: rtl/rom_loader_pkg.sv
// Shared types and lane constants for the ROM download router.
// Word entries combine a parameter-width address (declared in the top) with this payload.
package rom_loader_pkg;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_FULL = 2'b11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0]  ds;
        logic [15:0] data;
    } word_payload_t;

    function automatic logic [1:0] lane_ds(input logic lane);
        return lane ? DS_HI : DS_LO;
    endfunction

endpackage

// File: rtl/rom_word_fifo.sv
// Synchronous FIFO of packed word entries; DEPTH must be a power of two.
// A push while full succeeds only when a pop frees the slot in the same cycle.
module rom_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = logic [7:0]
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rom_loader_router.sv
// ROM download router: packs data_io bytes into 16-bit words and fans them out to SDRAM ports.
// Define ROM_CHECKSUM_EN to add a 16-bit running byte checksum output.
module rom_loader_router
    import rom_loader_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned ADDR_W     = 25,
    parameter logic [7:0]  ROM_INDEX  = 8'd0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [ADDR_W-1:0]    ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic [NUM_PORTS-1:0] port_en,
    input  logic [NUM_PORTS-1:0] port_ack,
    output logic [NUM_PORTS-1:0] port_req,
    output logic [ADDR_W-2:0]    port_a,
    output logic [1:0]           port_ds,
    output logic [15:0]          port_d,
    output logic                 rom_init,
    output logic                 busy,
    output logic                 done,
    output logic                 rom_loaded,
    output logic                 overflow
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);

    localparam int unsigned WADDR_W = ADDR_W - 1;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        word_payload_t      pl;
    } word_entry_t;

    logic rom_init_c, init_rise, init_fall, accept, lane;
    logic rom_init_q, wr_q;

    logic               hold_valid_q, hold_valid_d;
    logic [WADDR_W-1:0] hold_waddr_q, hold_waddr_d;
    logic [1:0]         hold_ds_q, hold_ds_d;
    logic [15:0]        hold_data_q, hold_data_d;
    logic [WADDR_W-1:0] byte_waddr;
    logic [1:0]         merged_ds;
    logic [15:0]        merged_data;

    logic        push, pop, fifo_full, fifo_empty;
    word_entry_t push_entry, fifo_head;

    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] req_q, req_d, mask_q, mask_d;
    logic [WADDR_W-1:0]   a_q, a_d;
    logic [1:0]           ds_q, ds_d;
    logic [15:0]          d_q, d_d;

    logic quiet;
    logic drain_q, drain_d, done_q, done_d, loaded_q, loaded_d, ovf_q, ovf_d;

    assign rom_init_c = ioctl_download & (ioctl_index == ROM_INDEX);
    assign init_rise  = rom_init_c & ~rom_init_q;
    assign init_fall  = ~rom_init_c & rom_init_q;
    assign accept     = rom_init_c & ioctl_wr & ~wr_q;
    assign lane       = ioctl_addr[0];
    assign byte_waddr = ioctl_addr[ADDR_W-1:1];

    // Packing: a byte either merges into the held word or displaces it; a completed word
    // is pushed the same cycle it fills, so at most one push happens per accepted byte.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_waddr_d = hold_waddr_q;
        hold_ds_d    = hold_ds_q;
        hold_data_d  = hold_data_q;
        push         = 1'b0;
        push_entry   = '{waddr: hold_waddr_q, pl: '{ds: hold_ds_q, data: hold_data_q}};
        merged_ds    = hold_ds_q | lane_ds(lane);
        merged_data  = lane ? {ioctl_dout, hold_data_q[7:0]} : {hold_data_q[15:8], ioctl_dout};
        if (accept) begin
            if (hold_valid_q && (hold_waddr_q == byte_waddr)) begin
                if (merged_ds == DS_FULL) begin
                    push         = 1'b1;
                    push_entry   = '{waddr: hold_waddr_q, pl: '{ds: merged_ds, data: merged_data}};
                    hold_valid_d = 1'b0;
                end else begin
                    hold_ds_d   = merged_ds;
                    hold_data_d = merged_data;
                end
            end else begin
                push         = hold_valid_q;
                hold_valid_d = 1'b1;
                hold_waddr_d = byte_waddr;
                hold_ds_d    = lane_ds(lane);
                hold_data_d  = lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
            end
        end else if (init_fall && hold_valid_q) begin
            push         = 1'b1;
            hold_valid_d = 1'b0;
        end
    end

    rom_word_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (word_entry_t)
    ) u_fifo (
        .clk       (clk_sys),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        mask_d  = mask_q;
        a_d     = a_q;
        ds_d    = ds_q;
        d_d     = d_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    a_d     = fifo_head.waddr;
                    ds_d    = fifo_head.pl.ds;
                    d_d     = fifo_head.pl.data;
                    mask_d  = port_en;
                    req_d   = req_q ^ port_en;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (((port_ack ^ req_q) & mask_q) == '0) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign quiet = ~hold_valid_q & fifo_empty & (state_q == IDLE);

    always_comb begin
        drain_d  = drain_q;
        done_d   = 1'b0;
        loaded_d = loaded_q;
        ovf_d    = ovf_q;
        if (init_rise) begin
            drain_d  = 1'b0;
            loaded_d = 1'b0;
            ovf_d    = 1'b0;
        end else if (init_fall) begin
            drain_d = 1'b1;
        end else if (drain_q && quiet) begin
            drain_d  = 1'b0;
            done_d   = 1'b1;
            loaded_d = 1'b1;
        end
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rom_init_q   <= 1'b0;
            wr_q         <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_waddr_q <= '0;
            hold_ds_q    <= '0;
            hold_data_q  <= '0;
            state_q      <= IDLE;
            req_q        <= '0;
            mask_q       <= '0;
            a_q          <= '0;
            ds_q         <= '0;
            d_q          <= '0;
            drain_q      <= 1'b0;
            done_q       <= 1'b0;
            loaded_q     <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            rom_init_q   <= rom_init_c;
            wr_q         <= ioctl_wr;
            hold_valid_q <= hold_valid_d;
            hold_waddr_q <= hold_waddr_d;
            hold_ds_q    <= hold_ds_d;
            hold_data_q  <= hold_data_d;
            state_q      <= state_d;
            req_q        <= req_d;
            mask_q       <= mask_d;
            a_q          <= a_d;
            ds_q         <= ds_d;
            d_q          <= d_d;
            drain_q      <= drain_d;
            done_q       <= done_d;
            loaded_q     <= loaded_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] csum_q, csum_d, csum_base;

    // A byte accepted in the same cycle rom_init rises belongs to the new download.
    always_comb begin
        csum_base = init_rise ? '0 : csum_q;
        csum_d    = accept ? csum_base + {8'h00, ioctl_dout} : csum_base;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

    assign port_req   = req_q;
    assign port_a     = a_q;
    assign port_ds    = ds_q;
    assign port_d     = d_q;
    assign rom_init   = rom_init_c;
    assign busy       = hold_valid_q | ~fifo_empty | (state_q == WAIT);
    assign done       = done_q;
    assign rom_loaded = loaded_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_rom_loader_router.sv
// Self-checking bench for rom_loader_router: vector table plus corner-case sequences,
// with an issue scoreboard and a delayed toggle-ack responder per port.
module tb_rom_loader_router;

    localparam int unsigned NP = 2;
    localparam int unsigned AW = 25;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [NP-1:0] port_en;
    logic [NP-1:0] port_ack;
    logic [NP-1:0] port_req;
    logic [AW-2:0] port_a;
    logic [1:0]    port_ds;
    logic [15:0]   port_d;
    logic          rom_init, busy, done, rom_loaded, overflow;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    always #5 clk_sys = ~clk_sys;

    rom_loader_router #(
        .NUM_PORTS  (NP),
        .ADDR_W     (AW),
        .ROM_INDEX  (8'd0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .port_en        (port_en),
        .port_ack       (port_ack),
        .port_req       (port_req),
        .port_a         (port_a),
        .port_ds        (port_ds),
        .port_d         (port_d),
        .rom_init       (rom_init),
        .busy           (busy),
        .done           (done),
        .rom_loaded     (rom_loaded),
        .overflow       (overflow)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    typedef struct {
        logic [AW-2:0] a;
        logic [1:0]    ds;
        logic [15:0]   d;
        logic [NP-1:0] en;
    } exp_t;

    typedef struct {
        int unsigned start;
        int unsigned nbytes;
        logic [7:0]  dbase;
        logic [1:0]  en;
        int unsigned exp_issues;
        logic        exp_loaded;
    } vec_t;

    exp_t          exp_q[$];
    int unsigned   n_vec = 0;
    int unsigned   n_miss = 0;
    int unsigned   issues = 0;
    int unsigned   done_cnt = 0;
    logic          mon_en = 1'b0;
    logic          ack_en = 1'b1;
    logic [NP-1:0] prev_req = '0;
    int unsigned   ack_dly [NP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [7:0] b, input int unsigned i);
        logic [31:0] p;
        p = b * (i + 1);
        return p[7:0];
    endfunction

    // Scoreboard: every observed req toggle must match the next expected word.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (mon_en && port_req != prev_req) begin
                issues++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_issue: got req=%b a=0x%0h d=0x%0h, expected no issue", port_req, port_a, port_d);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("issue_addr", 32'(port_a), 32'(e.a));
                    check("issue_ds", 32'(port_ds), 32'(e.ds));
                    check("issue_data", 32'(port_d), 32'(e.d));
                    check("issue_toggle_mask", 32'(port_req ^ prev_req), 32'(e.en));
                end
            end
            if (mon_en && done) done_cnt++;
            prev_req = port_req;
        end
    end

    // Each port acks a pending request three cycles later while ack_en is set.
    initial begin
        forever begin
            @(negedge clk_sys);
            for (int i = 0; i < NP; i++) begin
                if (ack_en && port_ack[i] != port_req[i]) begin
                    if (ack_dly[i] >= 2) begin
                        port_ack[i] = ~port_ack[i];
                        ack_dly[i]  = 0;
                    end else begin
                        ack_dly[i]++;
                    end
                end else begin
                    ack_dly[i] = 0;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_expected(input int unsigned start, input int unsigned n, input logic [7:0] dbase,
                                 input logic [1:0] en, input int unsigned max_push);
        int unsigned last;
        int unsigned pushed;
        exp_t e;
        last   = start + n - 1;
        pushed = 0;
        for (int unsigned w = start / 2; w <= last / 2 && pushed < max_push; w++) begin
            e.a  = (AW - 1)'(w);
            e.ds = '0;
            e.d  = '0;
            e.en = en;
            if (2 * w >= start) begin
                e.ds[0]  = 1'b1;
                e.d[7:0] = byte_at(dbase, 2 * w - start);
            end
            if (2 * w + 1 <= last) begin
                e.ds[1]   = 1'b1;
                e.d[15:8] = byte_at(dbase, 2 * w + 1 - start);
            end
            if (en != '0) exp_q.push_back(e);
            pushed++;
        end
    endtask

    task automatic begin_dl(input logic [1:0] en, input logic [7:0] idx);
        @(negedge clk_sys);
        port_en        = en;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic drive_byte(input int unsigned addr, input logic [7:0] data);
        ioctl_addr = AW'(addr);
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget, output bit seen);
        seen = 1'b0;
        for (int unsigned c = 0; c < budget && !seen; c++) begin
            @(posedge clk_sys);
            #1;
            if (done) seen = 1'b1;
        end
    endtask

    initial begin
        vec_t        vecs[5];
        bit          seen;
        int unsigned base_issues;
        int unsigned base_done;
        logic [15:0] sum;

        vecs[0] = '{start: 0,  nbytes: 2, dbase: 8'h11, en: 2'b11, exp_issues: 1, exp_loaded: 1'b1};
        vecs[1] = '{start: 0,  nbytes: 5, dbase: 8'h23, en: 2'b11, exp_issues: 3, exp_loaded: 1'b1};
        vecs[2] = '{start: 3,  nbytes: 4, dbase: 8'h35, en: 2'b01, exp_issues: 3, exp_loaded: 1'b1};
        vecs[3] = '{start: 10, nbytes: 6, dbase: 8'h49, en: 2'b10, exp_issues: 3, exp_loaded: 1'b1};
        vecs[4] = '{start: 20, nbytes: 3, dbase: 8'h5b, en: 2'b00, exp_issues: 0, exp_loaded: 1'b1};

        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        port_en = 2'b11;
        port_ack = '0;
        for (int i = 0; i < NP; i++) ack_dly[i] = 0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_port_req", 32'(port_req), 32'h0);
        check("reset_port_a", 32'(port_a), 32'h0);
        check("reset_port_ds", 32'(port_ds), 32'h0);
        check("reset_port_d", 32'(port_d), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_rom_loaded", 32'(rom_loaded), 32'h0);
        check("reset_overflow", 32'(overflow), 32'h0);
`ifdef ROM_CHECKSUM_EN
        check("reset_checksum", 32'(checksum), 32'h0);
`endif
        @(negedge clk_sys);
        reset = 1'b0;
        mon_en = 1'b1;

        for (int k = 0; k < 5; k++) begin
            base_issues = issues;
            push_expected(vecs[k].start, vecs[k].nbytes, vecs[k].dbase, vecs[k].en, 100);
            begin_dl(vecs[k].en, 8'd0);
            check("rom_init_high", 32'(rom_init), 32'h1);
            check("restart_clears_loaded", 32'(rom_loaded), 32'h0);
            sum = '0;
            for (int unsigned i = 0; i < vecs[k].nbytes; i++) begin
                if (k == 2 && i == 0) port_ack[1] = ~port_ack[1];
                drive_byte(vecs[k].start + i, byte_at(vecs[k].dbase, i));
                sum = sum + {8'h00, byte_at(vecs[k].dbase, i)};
            end
            end_dl();
            wait_done(300, seen);
            check("done_seen", 32'(seen), 32'h1);
            check("issue_count", issues - base_issues, vecs[k].exp_issues);
            check("rom_loaded", 32'(rom_loaded), 32'(vecs[k].exp_loaded));
            check("words_left", exp_q.size(), 32'h0);
            check("no_overflow", 32'(overflow), 32'h0);
            check("idle_after_done", 32'(busy), 32'h0);
`ifdef ROM_CHECKSUM_EN
            check("checksum_vec", 32'(checksum), 32'(sum));
`endif
            repeat (4) @(negedge clk_sys);
        end

        // Odd byte before even byte of the same word still merges into one issue.
        base_issues = issues;
        exp_q.push_back('{a: (AW - 1)'(4), ds: 2'b11, d: 16'hABCD, en: 2'b11});
        begin_dl(2'b11, 8'd0);
        drive_byte(9, 8'hAB);
        drive_byte(8, 8'hCD);
        end_dl();
        wait_done(300, seen);
        check("odd_even_done", 32'(seen), 32'h1);
        check("odd_even_issues", issues - base_issues, 32'h1);

        // Withheld acks: FIFO fills, the fifth word is dropped, four issue after release.
        base_issues = issues;
        ack_en = 1'b0;
        push_expected(0, 10, 8'h07, 2'b11, 4);
        begin_dl(2'b11, 8'd0);
        for (int unsigned i = 0; i < 10; i++) drive_byte(i, byte_at(8'h07, i));
        end_dl();
        repeat (10) @(negedge clk_sys);
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_busy", 32'(busy), 32'h1);
        check("ovf_one_issue_stalled", issues - base_issues, 32'h1);
        ack_en = 1'b1;
        wait_done(400, seen);
        check("ovf_done", 32'(seen), 32'h1);
        check("ovf_issue_count", issues - base_issues, 32'h4);
        check("ovf_words_left", exp_q.size(), 32'h0);
        check("ovf_sticky", 32'(overflow), 32'h1);
        check("ovf_loaded", 32'(rom_loaded), 32'h1);

        // Reset while a request is outstanding abandons the word.
        base_issues = issues;
        ack_en = 1'b0;
        exp_q.push_back('{a: (AW - 1)'(32), ds: 2'b11, d: 16'h5AA5, en: 2'b11});
        begin_dl(2'b11, 8'd0);
        drive_byte(64, 8'hA5);
        drive_byte(65, 8'h5A);
        for (int c = 0; c < 20 && issues == base_issues; c++) @(negedge clk_sys);
        check("wait_issue_seen", issues - base_issues, 32'h1);
        repeat (3) @(negedge clk_sys);
        mon_en = 1'b0;
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(posedge clk_sys);
        #1;
        check("rst_wait_port_req", 32'(port_req), 32'h0);
        check("rst_wait_busy", 32'(busy), 32'h0);
        check("rst_wait_loaded", 32'(rom_loaded), 32'h0);
        check("rst_wait_overflow", 32'(overflow), 32'h0);
        @(negedge clk_sys);
        reset = 1'b0;
        port_ack = '0;
        exp_q.delete();
        ack_en = 1'b1;
        repeat (2) @(negedge clk_sys);
        mon_en = 1'b1;

        // Non-ROM index: strobes ignored, nothing issued, no done.
        base_issues = issues;
        base_done = done_cnt;
        begin_dl(2'b11, 8'd1);
        for (int unsigned i = 0; i < 4; i++) drive_byte(i, 8'hC0 + 8'(i));
        check("idx1_rom_init", 32'(rom_init), 32'h0);
        check("idx1_busy", 32'(busy), 32'h0);
        end_dl();
        repeat (30) @(negedge clk_sys);
        check("idx1_no_issue", issues - base_issues, 32'h0);
        check("idx1_no_done", done_cnt - base_done, 32'h0);
        check("idx1_not_loaded", 32'(rom_loaded), 32'h0);

`ifdef ROM_CHECKSUM_EN
        exp_q.push_back('{a: (AW - 1)'(0), ds: 2'b11, d: 16'hFFFF, en: 2'b11});
        begin_dl(2'b11, 8'd0);
        drive_byte(0, 8'hFF);
        drive_byte(1, 8'hFF);
        end_dl();
        wait_done(300, seen);
        check("csum_done", 32'(seen), 32'h1);
        check("csum_ff_ff", 32'(checksum), 32'h01FE);
`endif

        repeat (5) @(negedge clk_sys);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rom_loader_router.md
Name: rom_loader_router

Overview:
- Generalised ROM download controller between the data_io byte stream and N SDRAM write ports.
- Filters on download index and packs sequential bytes into 16-bit words with byte-lane strobes.
- Buffers words in a small FIFO, issues each word to every enabled port with a toggle req/ack handshake, and waits for all acks.
- Generates rom_loaded and done status used by the top-level reset logic.

Parameters:
- NUM_PORTS, 2: number of SDRAM write ports driven.
- ADDR_W, 25: ioctl byte-address width; word address is ADDR_W-1 bits.
- ROM_INDEX, 0: ioctl_index value accepted as a ROM download.
- FIFO_DEPTH, 4: word FIFO entries; power of two, at least 2.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  byte strobe; level, edge-detected internally.
- ioctl_addr  in  ADDR_W  byte address.
- ioctl_dout  in  8  byte data.
- port_en  in  NUM_PORTS  per-port enable, sampled at word issue.
- port_ack  in  NUM_PORTS  per-port toggle acknowledge.
- port_req  out  NUM_PORTS  per-port toggle request.
- port_a  out  ADDR_W-1  word address, shared by all ports.
- port_ds  out  2  byte strobes; [1] = odd/upper byte, [0] = even/lower byte.
- port_d  out  16  write data; odd byte in [15:8], even byte in [7:0].
- rom_init  out  1  ioctl_download & (ioctl_index == ROM_INDEX).
- busy  out  1  holding register valid, FIFO non-empty, or request outstanding.
- done  out  1  one-cycle pulse when a download has fully drained.
- rom_loaded  out  1  sticky; set with done.
- overflow  out  1  sticky; a push was attempted while the FIFO was full.

Behaviour:
- Reset values:
  - port_req = 0, port_a/port_ds/port_d = 0.
  - busy, done, rom_loaded, overflow = 0.
  - FIFO empty, holding register invalid, state IDLE.
- Byte accept: a rising edge of ioctl_wr while rom_init is high. Edges while rom_init is low are ignored.
- Packing: holding register {waddr, data, ds}.
  - Accepted byte with waddr == ioctl_addr[ADDR_W-1:1] and holding valid: merge the byte into its lane.
  - Otherwise: push the held word (if valid) and load the new byte alone.
  - Holding ds becomes 2'b11 after a merge: push it the same cycle and invalidate.
  - At most one push per accepted byte.
- Byte arrival order: lane = ioctl_addr[0], so odd-then-even bytes of the same word also merge.
- Download end: the cycle rom_init falls with holding valid, push the partial word (ds = 01 or 10).
- Issue FSM, IDLE -> WAIT -> IDLE:
  - IDLE with FIFO non-empty: drive port_a/ds/d from the FIFO head and latch mask = port_en.
  - Toggle port_req[i] for every masked i, then go to WAIT.
  - WAIT: stay until (port_ack ^ port_req) & mask == 0, then pop and return to IDLE.
  - Minimum 2 cycles per word.
  - mask == 0: pop in the next cycle with no toggles.
- Simultaneous push and pop are allowed at any fill level, including full, with no overflow.
- Full FIFO: push is dropped, overflow is set, and the existing contents are preserved.
- Done: after rom_init falls, the first cycle with holding invalid, FIFO empty and FSM IDLE pulses done and sets rom_loaded.
- Restart: a new rising edge of rom_init clears rom_loaded and overflow; port_req keeps its current phase.
- Input timing: ioctl_wr minimum spacing is 4 clk_sys cycles. Back-pressure is absorbed only by the FIFO.
- Reset mid-download: everything returns to reset values immediately. The in-flight word is abandoned, and port_req returns to 0.

Optional Feature:
- ROM_CHECKSUM_EN defined:
  - Adds output checksum [15:0]: a 16-bit wrapping sum of every accepted byte (zero-extended).
  - Cleared by reset and on each rising edge of rom_init; frozen at done.
- Not defined: the port is absent and no adder is generated.

Decomposition:
- Package rom_loader_pkg:
  - Word-entry typedef {waddr, ds, data}.
  - State enum {IDLE, WAIT}.
  - DS_LO = 2'b01, DS_HI = 2'b10, DS_FULL = 2'b11.
- Sub-module rom_word_fifo: synchronous FIFO parameterised by depth and entry type, with full, empty, push, pop and head outputs.

Test Plan:
- Bytes 0x11 @0, 0x22 @1 with acks returned after 3 cycles -> one issue: port_a = 0, ds = 11, port_d = 0x2211, both port_req bits toggled once, done after rom_init falls.
- 5 sequential bytes @0..4 then download end -> three words; last has port_a = 2, ds = 01, data[7:0] = byte 4; rom_loaded = 1.
- Acks withheld, 10 bytes at 4-cycle spacing -> FIFO fills, overflow = 1, exactly 4 words issued once acks resume.
- port_en = 2'b01 -> only port_req[0] toggles; port_ack[1] is ignored; the word pops after port_ack[0] matches.
- Reset asserted while in WAIT -> next cycle port_req = 0, busy = 0, FIFO empty, rom_loaded = 0.
- ioctl_index = 1 with strobes -> no requests, rom_init = 0, done never pulses; with ROM_CHECKSUM_EN, bytes 0xFF × 2 at index 0 -> checksum = 0x01FE.
